result_display: RTL and testbench

Sequential back-end for the calculator datapath: captures the 8-bit calculator result on a load strobe, converts it to three BCD digits with an iterative shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto a common-anode 3-digit seven-segment display. It sits directly downstream of the square/cube/factorial unit and drives the board display pins.

---
 rtl/result_display.sv | 138 +++++++++++++
 tb/tb_result_display.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// result_display: latches an 8-bit result, converts it to BCD by double-dabble, and scans it onto a 3-digit display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [2:0] an
);
    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] bcd_q, bcd_d, bcd_adj;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [DW-1:0] div_q;
    logic [1:0]  idx_q;
    logic [3:0]  digit;
    logic        blank;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  an_q, an_d;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        case (state_q)
            IDLE: if (load) begin
                shift_d = value;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = LATCH;
            end
            LATCH: begin
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        digit = (idx_q == 2'd0) ? ones_q : (idx_q == 2'd1) ? tens_q : hund_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_q == 2'd2 && hund_q == 4'd0) ||
                (idx_q == 2'd1 && hund_q == 4'd0 && tens_q == 4'd0);
`else
        blank = 1'b0;
`endif
        seg_d = blank ? 7'h7F : seg_code(digit);
        an_d  = (idx_q == 2'd0) ? 3'b110 : (idx_q == 2'd1) ? 3'b101 : 3'b011;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 3'b111;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            if (div_q == DW'(SCAN_DIV - 1)) begin
                div_q <= '0;
                idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign seg  = seg_q;
    assign an   = an_q;
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: directed checks of conversion latency, digit values and scan order for result_display.
// Expected segment values follow LEADING_ZERO_BLANK_EN when defined.
module tb_result_display;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic       load;
    logic       busy, done;
    logic [6:0] seg;
    logic [2:0] an;
    int passed = 0;
    int total = 0;

    result_display #(.SCAN_DIV(2)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .busy(busy), .done(done), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] segx(input logic [3:0] d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [6:0] exp_seg(input int pos, input logic [3:0] h, t, o);
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && h == 0) return 7'h7F;
        if (pos == 1 && h == 0 && t == 0) return 7'h7F;
`endif
        return segx(pos == 0 ? o : pos == 1 ? t : h);
    endfunction

    task automatic show(input logic [3:0] h, t, o);
        logic [2:0] seen = '0;
        int pos;
        repeat (6) begin
            step();
            pos = (an == 3'b110) ? 0 : (an == 3'b101) ? 1 : 2;
            chk("an_valid", 32'(an == 3'b110 || an == 3'b101 || an == 3'b011), 1);
            seen[pos] = 1'b1;
            chk("seg_digit", seg, exp_seg(pos, h, t, o));
        end
        chk("an_cover", seen, 3'b111);
    endtask

    task automatic conv(input logic [7:0] v, input logic [3:0] h, t, o);
        value = v;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("busy_start", busy, 1);
        chk("done_start", done, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("busy_conv", busy, 1);
            chk("done_conv", done, 0);
        end
        step();
        chk("busy_latch", busy, 0);
        chk("done_latch", done, 1);
        step();
        chk("done_clear", done, 0);
        show(h, t, o);
    endtask

    initial begin
        logic [2:0] an_seq [7] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110};
        int pos_seq [7] = '{0, 0, 1, 1, 2, 2, 0};
        reset = 1'b0;
        load = 1'b0;
        value = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 3'b111);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("idle_an", an, an_seq[i]);
            chk("idle_seg", seg, exp_seg(pos_seq[i], 0, 0, 0));
        end

        conv(8'd87, 0, 8, 7);
        conv(8'd176, 1, 7, 6);
        conv(8'd255, 2, 5, 5);
        conv(8'd0, 0, 0, 0);

        value = 8'd87;
        load = 1'b1;
        step();
        chk("hold_busy0", busy, 1);
        value = 8'd200;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("hold_done_conv", done, 0);
        end
        step();
        chk("hold_done9", done, 1);
        chk("hold_busy9", busy, 0);
        step();
        load = 1'b0;
        chk("hold_busy10", busy, 1);
        chk("hold_done10", done, 0);
        show(0, 8, 7);
        step();
        step();
        chk("second_done18", done, 0);
        chk("second_busy18", busy, 1);
        step();
        chk("second_done19", done, 1);
        step();
        show(2, 0, 0);

        value = 8'd255;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_seg", seg, 7'h7F);
        chk("abort_an", an, 3'b111);
        load = 1'b1;
        step();
        chk("rst_wins_busy", busy, 0);
        load = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        show(0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
